// File: rtl/game_2048_pkg.sv
// Shared types and constants for the 2048 game datapath.
package game_2048_pkg;

  localparam int TILE_W  = 12;
  localparam int BOARD_N = 4;

  typedef logic [TILE_W-1:0] tile_t;
  typedef tile_t [BOARD_N-1:0][BOARD_N-1:0] board_t;

  localparam tile_t TILE_EMPTY = 12'd0;
  localparam tile_t TILE_TWO   = 12'd2;
  localparam tile_t TILE_FOUR  = 12'd4;

  // Tile spawner control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2,
    FULL  = 2'd3
  } spawn_state_e;

  // One step of the 16-bit Galois LFSR (right shift, taps 16'hB400).
  function automatic logic [15:0] lfsr16_step(input logic [15:0] s);
    lfsr16_step = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a nonzero seed keeps it off the all-zero lock-up state.
module lfsr16
  import game_2048_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Advance the sequence by one step every cycle.
  always_comb begin
    state_d = lfsr16_step(state_q);
  end

  // State register, reloaded with the seed on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/tile_spawner.sv
// Places one new 2 or 4 tile into a pseudo-randomly chosen empty cell of the board,
// scanning one cell per cycle from a random start, or reports that the board is full.
module tile_spawner
  import game_2048_pkg::*;
#(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned FOUR_THRESH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spawn_req,
  input  board_t      matrix,
  output logic        busy,
  output logic        wr_en,
  output logic [1:0]  wr_row,
  output logic [1:0]  wr_col,
  output tile_t       wr_data,
  output logic        done,
  output logic        full
);

  localparam logic [4:0] FOUR_THRESH_W = 5'(FOUR_THRESH);

  logic [15:0]  lfsr_state;
  logic         unused_lfsr_bits;

  spawn_state_e state_q, state_d;
  logic [3:0]   start_q, start_d;
  logic [3:0]   sel_q, sel_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         wr_en_q, wr_en_d;
  logic [1:0]   wr_row_q, wr_row_d;
  logic [1:0]   wr_col_q, wr_col_d;
  tile_t        wr_data_q, wr_data_d;
  logic         done_q, done_d;
  logic         full_q, full_d;

  logic [3:0]   idx;
  logic         cell_empty;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .state (lfsr_state)
  );

  assign unused_lfsr_bits = ^{lfsr_state[15:12], lfsr_state[7:4]};

  // Cell under examination this cycle; the 4-bit add wraps around the board.
  always_comb begin
    idx        = start_q + cnt_q;
    cell_empty = (matrix[idx[3:2]][idx[1:0]] == TILE_EMPTY);
  end

  // Next-state and registered-output logic for the scan/write sequence.
  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    full_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (spawn_req) begin
          start_d = lfsr_state[3:0];
          sel_d   = lfsr_state[11:8];
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (cell_empty) begin
          wr_row_d  = idx[3:2];
          wr_col_d  = idx[1:0];
          wr_data_d = ({1'b0, sel_q} < FOUR_THRESH_W) ? TILE_FOUR : TILE_TWO;
          wr_en_d   = 1'b1;
          done_d    = 1'b1;
          state_d   = WRITE;
        end else if (cnt_q == 4'd15) begin
          done_d  = 1'b1;
          full_d  = 1'b1;
          state_d = FULL;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WRITE, FULL: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any scan without writing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= 4'd0;
      sel_q     <= 4'd0;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_row_q  <= 2'd0;
      wr_col_q  <= 2'd0;
      wr_data_q <= TILE_EMPTY;
      done_q    <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      full_q    <= full_d;
    end
  end

  assign busy    = busy_q;
  assign wr_en   = wr_en_q;
  assign wr_row  = wr_row_q;
  assign wr_col  = wr_col_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign full    = full_q;

endmodule

// File: tb/tb_tile_spawner.sv
// Self-checking bench for tile_spawner: expected spawns are queued when a request is
// driven and compared when the DUT signals done.
module tb_tile_spawner;
  import game_2048_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    int         cyc;
    logic       full;
    logic [1:0] row;
    logic [1:0] col;
    tile_t      data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        spawn_req;
  board_t      matrix;
  logic        busy;
  logic        wr_en;
  logic [1:0]  wr_row;
  logic [1:0]  wr_col;
  tile_t       wr_data;
  logic        done;
  logic        full;

  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          fours  = 0;
  logic [15:0] hit    = 16'h0000;
  logic [15:0] m_lfsr;
  exp_t        sb[$];

  tile_spawner #(.SEED(SEED), .FOUR_THRESH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spawn_req (spawn_req),
    .matrix    (matrix),
    .busy      (busy),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .done      (done),
    .full      (full)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to time-stamp expected completions.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference Galois LFSR (right shift, taps 16'hB400), reset alongside the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  // Counts every comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drives one accepted request from the current negedge, queues its expected result,
  // re-pulses spawn_req in the cycles flagged in extra, and checks busy each cycle.
  task automatic applyStimulus(input board_t b, input logic [31:0] extra);
    exp_t       e;
    logic [3:0] start;
    logic [3:0] sel;
    logic [3:0] idx;
    logic       found;
    int         k;
    int         n_done;
    matrix = b;
    start  = m_lfsr[3:0];
    sel    = m_lfsr[11:8];
    found  = 1'b0;
    k      = 0;
    e.row  = 2'd0;
    e.col  = 2'd0;
    for (int i = 0; i < 16; i++) begin
      idx = start + 4'(i);
      if (!found && b[idx[3:2]][idx[1:0]] == 12'd0) begin
        found = 1'b1;
        k     = i;
        e.row = idx[3:2];
        e.col = idx[1:0];
      end
    end
    n_done = found ? (2 + k) : 17;
    e.cyc  = cyc + n_done;
    e.full = !found;
    e.data = (sel < 4'd2) ? 12'd4 : 12'd2;
    sb.push_back(e);
    spawn_req = 1'b1;
    for (int n = 1; n <= n_done + 1; n++) begin
      @(negedge clk);
      spawn_req = (n <= n_done) ? extra[n] : 1'b0;
      checkOutput("busy", 32'(busy), 32'(n <= n_done));
    end
    spawn_req = 1'b0;
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: pops the scoreboard on done and polices stray strobes.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (wr_en) checkOutput("target_empty", 32'(matrix[wr_row][wr_col]), 32'd0);
      if (!done) begin
        checkOutput("stray_wr_en", 32'(wr_en), 32'd0);
        checkOutput("stray_full", 32'(full), 32'd0);
      end else if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("done_cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("full", 32'(full), 32'(e.full));
        checkOutput("wr_en", 32'(wr_en), 32'(!e.full));
        if (!e.full) begin
          checkOutput("wr_row", 32'(wr_row), 32'(e.row));
          checkOutput("wr_col", 32'(wr_col), 32'(e.col));
          checkOutput("wr_data", 32'(wr_data), 32'(e.data));
          if (wr_data == 12'd4) fours++;
          hit[{wr_row, wr_col}] = 1'b1;
        end
      end
    end
  end

  board_t b_empty;
  board_t b_full;
  board_t b_one;

  initial begin
    rst_n     = 1'b0;
    spawn_req = 1'b0;
    matrix    = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        b_empty[r][c] = 12'd0;
        b_full[r][c]  = 12'd2;
        b_one[r][c]   = 12'd8;
      end
    end
    b_one[2][3] = 12'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_wr_row", 32'(wr_row), 32'd0);
    checkOutput("rst_wr_col", 32'(wr_col), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] empty board");
    applyStimulus(b_empty, 32'd0);

    $display("[TB] full board");
    applyStimulus(b_full, 32'd0);

    $display("[TB] single empty cell [2][3]");
    for (int i = 0; i < 5; i++) begin
      repeat (i) @(negedge clk);
      applyStimulus(b_one, 32'd0);
    end

    $display("[TB] full board with extra requests in cycles 3 and 10");
    applyStimulus(b_full, 32'h0000_0408);
    repeat (20) @(negedge clk);

    $display("[TB] reset mid-scan");
    matrix    = b_empty;
    spawn_req = 1'b1;
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    spawn_req = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_wr_en", 32'(wr_en), 32'd0);
      checkOutput("midrst_done", 32'(done), 32'd0);
      checkOutput("midrst_full", 32'(full), 32'd0);
      checkOutput("midrst_wr_row", 32'(wr_row), 32'd0);
      checkOutput("midrst_wr_col", 32'(wr_col), 32'd0);
      checkOutput("midrst_wr_data", 32'(wr_data), 32'd0);
    end
    rst_n = 1'b1;
    applyStimulus(b_empty, 32'd0);
    repeat (5) @(negedge clk);

    $display("[TB] 1000 spawns on an empty board");
    fours = 0;
    hit   = 16'h0000;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(b_empty, 32'd0);
    end
    checkOutput("four_ratio_in_band", 32'(fours >= 95 && fours <= 155), 32'd1);
    checkOutput("all_cells_hit", 32'(hit), 32'h0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
